// File: rtl/hex_display_arbiter.sv
// Arbitrates six seven-segment displays between an HPS PIO word, a timed fabric
// request and a debounced pushbutton banner override; every output is registered.
module hex_display_arbiter #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] hps_hex3_hex0,
  input  logic [15:0] hps_hex5_hex4,
  input  logic        hps_req,
  input  logic        fab_req,
  input  logic [23:0] fab_digits,
  input  logic        key_n,
  output logic        fab_ack,
  output logic [1:0]  owner,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5
);

  localparam int TMR_W = $clog2(HOLD_CYCLES + 1);
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [6:0] SEG_BANNER = 7'b0111111;

  typedef enum logic [1:0] {
    OWN_IDLE   = 2'd0,
    OWN_HPS    = 2'd1,
    OWN_FAB    = 2'd2,
    OWN_BANNER = 2'd3
  } owner_e;

  logic              key_sync_p0;
  logic              key_sync_p1;
  logic              key_press;
  logic              key_held;
  logic [DB_W-1:0]   db_cnt;
  logic [TMR_W-1:0]  hold_tmr;
  logic [23:0]       digit_buf;
  logic [23:0]       digits_sel;
  logic [47:0]       hps_segs;
  owner_e            own_nxt;
  owner_e            own_p1;
  logic [6:0]        hex_nxt [6];
  logic [6:0]        hex_p1  [6];
  logic              vld_p1;
  logic              unused_bits;

  // Active-low hex decode, bit order gfedcba.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  assign hps_segs    = {hps_hex5_hex4, hps_hex3_hex0};
  assign unused_bits = ^{hps_hex3_hex0[31], hps_hex3_hex0[23], hps_hex3_hex0[15],
                         hps_hex3_hex0[7], hps_hex5_hex4[15], hps_hex5_hex4[7]};

  // Key synchronizer: idles at 1 (button released).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_sync_p0 <= 1'b1;
      key_sync_p1 <= 1'b1;
    end else begin
      key_sync_p0 <= key_n;
      key_sync_p1 <= key_sync_p0;
    end
  end

  assign key_press = ~key_sync_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt   <= '0;
      key_held <= 1'b0;
    end else if (key_press != key_held) begin
      if (db_cnt == DB_LAST) begin
        key_held <= key_press;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Requests always land, whoever owns the displays; the timer runs under the banner too.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_tmr  <= '0;
      digit_buf <= '0;
    end else if (fab_req) begin
      hold_tmr  <= HOLD_LOAD;
      digit_buf <= fab_digits;
    end else if (hold_tmr != '0) begin
      hold_tmr <= hold_tmr - TMR_W'(1);
    end
  end

  always_comb begin
    own_nxt = OWN_IDLE;
    if (key_held)
      own_nxt = OWN_BANNER;
    else if ((hold_tmr != '0) || fab_req)
      own_nxt = OWN_FAB;
    else if (hps_req)
      own_nxt = OWN_HPS;
  end

  // A request in this very cycle is shown immediately, before the buffer catches it.
  assign digits_sel = fab_req ? fab_digits : digit_buf;

  always_comb begin
    for (int k = 0; k < 6; k++) begin
      hex_nxt[k] = SEG_BLANK;
      case (own_nxt)
        OWN_HPS:    hex_nxt[k] = ~hps_segs[8*k +: 7];
        OWN_FAB:    hex_nxt[k] = hex_decode(digits_sel[4*k +: 4]);
        OWN_BANNER: hex_nxt[k] = SEG_BANNER;
        default:    hex_nxt[k] = SEG_BLANK;
      endcase
    end
  end

  // Output register stage p1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      own_p1 <= OWN_IDLE;
      vld_p1 <= 1'b0;
      for (int k = 0; k < 6; k++) hex_p1[k] <= SEG_BLANK;
    end else begin
      own_p1 <= own_nxt;
      vld_p1 <= fab_req;
      for (int k = 0; k < 6; k++) hex_p1[k] <= hex_nxt[k];
    end
  end

  assign owner   = own_p1;
  assign fab_ack = vld_p1;
  assign HEX0    = hex_p1[0];
  assign HEX1    = hex_p1[1];
  assign HEX2    = hex_p1[2];
  assign HEX3    = hex_p1[3];
  assign HEX4    = hex_p1[4];
  assign HEX5    = hex_p1[5];

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed and randomized bench for hex_display_arbiter against a cycle-level
// reference model built from the display-arbitration rules.
module tb_hex_display_arbiter;

  localparam int DEB  = 4;
  localparam int HOLD = 10;

  logic        clk;
  logic        reset_n;
  logic [31:0] hps_hex3_hex0;
  logic [15:0] hps_hex5_hex4;
  logic        hps_req;
  logic        fab_req;
  logic [23:0] fab_digits;
  logic        key_n;
  logic        fab_ack;
  logic [1:0]  owner;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  hex_display_arbiter #(.DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .hps_hex3_hex0(hps_hex3_hex0),
    .hps_hex5_hex4(hps_hex5_hex4), .hps_req(hps_req), .fab_req(fab_req),
    .fab_digits(fab_digits), .key_n(key_n), .fab_ack(fab_ack), .owner(owner),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [6:0]  seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic        key_hist [$];
  bit          m_held;
  int          m_run;
  int          m_timer;
  logic [23:0] m_buf;
  logic [1:0]  e_owner;
  logic        e_ack;
  logic [41:0] e_hex;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    key_hist = '{1'b1, 1'b1};
    m_held   = 0;
    m_run    = 0;
    m_timer  = 0;
    m_buf    = '0;
    e_owner  = 2'd0;
    e_ack    = 1'b0;
    e_hex    = {6{7'h7F}};
  endtask

  // Predicts the registered outputs produced by the coming clock edge.
  task automatic model_eval();
    logic [47:0] hps_w;
    logic [23:0] dig;
    bit pressed;
    hps_w = {hps_hex5_hex4, hps_hex3_hex0};
    dig   = fab_req ? fab_digits : m_buf;
    if (m_held)                      e_owner = 2'd3;
    else if (m_timer > 0 || fab_req) e_owner = 2'd2;
    else if (hps_req)                e_owner = 2'd1;
    else                             e_owner = 2'd0;
    for (int k = 0; k < 6; k++) begin
      case (e_owner)
        2'd0: e_hex[7*k +: 7] = 7'h7F;
        2'd1: e_hex[7*k +: 7] = ~hps_w[8*k +: 7];
        2'd2: e_hex[7*k +: 7] = seg_tab[dig[4*k +: 4]];
        default: e_hex[7*k +: 7] = 7'b0111111;
      endcase
    end
    e_ack = fab_req;
    if (fab_req) begin
      m_timer = HOLD;
      m_buf   = fab_digits;
    end else if (m_timer > 0) begin
      m_timer = m_timer - 1;
    end
    // key_hist[1] is the key level that has crossed both synchronizer flops
    pressed = (key_hist[1] == 1'b0);
    if (pressed != m_held) begin
      m_run++;
      if (m_run == DEB) begin
        m_held = pressed;
        m_run  = 0;
      end
    end else begin
      m_run = 0;
    end
    key_hist.push_front(key_n);
    void'(key_hist.pop_back());
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".owner"}, 64'(owner), 64'(e_owner));
    chk({tag, ".ack"}, 64'(fab_ack), 64'(e_ack));
    chk({tag, ".hex"}, 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), 64'(e_hex));
  endtask

  task automatic step(input string tag);
    model_eval();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    model_reset();
    #1;
    compare_all({tag, ".async"});
    @(posedge clk);
    #1;
    compare_all({tag, ".held"});
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n       = 1'b1;
    hps_hex3_hex0 = '0;
    hps_hex5_hex4 = '0;
    hps_req       = 1'b0;
    fab_req       = 1'b0;
    fab_digits    = '0;
    key_n         = 1'b1;
    model_reset();
    #2;
    do_reset("rst0");
    step("idle");

    // HPS owns the displays
    hps_req       = 1'b1;
    hps_hex3_hex0 = 32'h0000_0006;
    step("hps");
    chk("hps.hex0", 64'(HEX0), 64'(7'b1111001));
    chk("hps.hex1", 64'(HEX1), 64'(7'h7F));
    chk("hps.owner", 64'(owner), 64'd1);

    // Fabric request and full hold
    fab_req    = 1'b1;
    fab_digits = 24'hFEDCBA;
    step("fab");
    chk("fab.ack", 64'(fab_ack), 64'd1);
    chk("fab.hex0", 64'(HEX0), 64'(7'b0001000));
    chk("fab.hex5", 64'(HEX5), 64'(7'b0001110));
    fab_req = 1'b0;
    for (int i = 0; i < HOLD + 2; i++) step("hold");
    chk("hold.back_hps", 64'(owner), 64'd1);

    // Bouncy key press, then release
    key_n = 1'b0; step("bnc");
    key_n = 1'b1; step("bnc");
    key_n = 1'b1; step("bnc");
    key_n = 1'b0;
    for (int i = 0; i < DEB + 4; i++) step("press");
    chk("press.owner", 64'(owner), 64'd3);
    chk("press.hex3", 64'(HEX3), 64'(7'b0111111));
    key_n = 1'b1;
    for (int i = 0; i < DEB + 4; i++) step("release");
    chk("release.owner", 64'(owner), 64'd1);

    // Restart of the hold by a new request late in the hold
    fab_req = 1'b1; fab_digits = 24'h123456; step("fab2");
    fab_req = 1'b0;
    for (int i = 0; i < HOLD && m_timer != 3; i++) step("wait3");
    fab_req = 1'b1; fab_digits = 24'h000001; step("restart");
    chk("restart.hex0", 64'(HEX0), 64'(7'b1111001));
    chk("restart.ack", 64'(fab_ack), 64'd1);
    fab_req = 1'b0;
    for (int i = 0; i < HOLD + 2; i++) step("rhold");

    // Request in the cycle the banner engages
    key_n = 1'b0;
    for (int i = 0; i < 12 && !m_held; i++) step("kwait");
    chk("kwait.held", 64'(m_held), 64'd1);
    fab_req = 1'b1; fab_digits = 24'hABCDEF; step("collide");
    chk("collide.owner", 64'(owner), 64'd3);
    chk("collide.ack", 64'(fab_ack), 64'd1);
    fab_req = 1'b0;
    for (int i = 0; i < 5; i++) step("banner");
    key_n = 1'b1;
    for (int i = 0; i < HOLD + 4; i++) step("resume");

    // Reset in the middle of a hold
    fab_req = 1'b1; fab_digits = 24'h987654; step("fab3");
    fab_req = 1'b0; step("fab3b");
    do_reset("rst_mid");
    hps_req = 1'b0;
    for (int i = 0; i < 4; i++) step("post_rst");
    chk("post_rst.owner", 64'(owner), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset("rnd_rst");
      if ($urandom_range(0, 9) == 0) hps_req = ~hps_req;
      hps_hex3_hex0 = $urandom;
      hps_hex5_hex4 = 16'($urandom);
      fab_req       = ($urandom_range(0, 11) == 0);
      fab_digits    = 24'($urandom);
      if ($urandom_range(0, 5) == 0) key_n = ~key_n;
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hex_display_arbiter.md
HEX_DISPLAY_ARBITER -- requirements
Module: hex_display_arbiter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000: stable cycles required before a key level change is accepted (20 ms at 50 MHz).
REQ-002 Parameter HOLD_CYCLES, default 50000000: cycles the fabric source owns the displays per request (1 s at 50 MHz).
REQ-003 clk  input  1  system clock (50 MHz); all logic is on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 hps_hex3_hex0  input  32  HPS PIO segment word; byte k bits [6:0] drive HEXk, active-high lit; bit 7 of each byte ignored.
REQ-006 hps_hex5_hex4  input  16  HPS PIO segment word for HEX4 (byte 0) and HEX5 (byte 1), same format.
REQ-007 hps_req  input  1  level; HPS wants the displays.
REQ-008 fab_req  input  1  single-cycle request strobe from fabric logic.
REQ-009 fab_digits  input  24  six 4-bit hex nibbles; nibble k shows on HEXk; sampled only when fab_req=1.
REQ-010 key_n  input  1  raw pushbutton, active-low, asynchronous to clk; held = banner override.
REQ-011 fab_ack  output  1  one-cycle pulse, the cycle after fab_req is accepted.
REQ-012 owner  output  2  current owner: 0 IDLE, 1 HPS, 2 FAB, 3 BANNER.
REQ-013 HEX0..HEX5  output  7 each  registered segment drive, active-low (0 = lit).

Function
REQ-014 key_n SHALL pass through a 2-flop synchronizer, then a debounce counter; key_held changes only after the synchronized level differs from key_held for DEBOUNCE_CYCLES consecutive cycles; any bounce resets the count.
REQ-015 fab_req=1 SHALL always be accepted, in every state: fab_digits latched into the digit buffer, hold timer loaded with HOLD_CYCLES, fab_ack=1 next cycle.
REQ-016 Hold timer SHALL decrement by 1 per cycle while nonzero, in every state including BANNER; it stops at 0 and never wraps.
REQ-017 Owner selection, evaluated every cycle, priority: key_held=1 -> BANNER; else timer nonzero or fab_req this cycle -> FAB; else hps_req=1 -> HPS; else IDLE.
REQ-018 A fab_req during FAB SHALL replace the buffered digits and reload the timer to HOLD_CYCLES (restart, not extend).
REQ-019 On banner release with timer nonzero, FAB SHALL resume showing the buffered digits for the remaining count.
REQ-020 fab_req and key_held rising in the same cycle: BANNER wins; request is still latched and acked.
REQ-021 Display per owner: IDLE all 7'h7F; HPS HEXk = bitwise NOT of the HPS segment byte k [6:0]; FAB HEXk = hex decode of nibble k; BANNER all 7'b0111111 (centre bar).
REQ-022 Hex decode (active-low, bit order gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-023 owner and HEX outputs SHALL be registered: a change in inputs or owner appears on outputs exactly 1 cycle later; HPS data passes through live while HPS owns.
REQ-024 hps_req deassertion during HPS SHALL return to IDLE (blank) on the next evaluation; no handover glitch beyond the 1-cycle register.

Reset
REQ-025 While reset_n=0: HEX0..HEX5 = 7'h7F, owner = 0, fab_ack = 0, hold timer = 0, digit buffer = 0, debounce counter = 0, key_held = 0, synchronizer flops = 1 (released).
REQ-026 Reset assertion mid-hold or mid-debounce SHALL abort immediately; after release, no pending FAB grant or banner survives.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10)
REQ-027 Reset then hps_req=1, hps_hex3_hex0=32'h0000_0006 -> owner=1, HEX0=7'b1111001, HEX1..HEX5=7'h7F one cycle later.
REQ-028 fab_req pulse, fab_digits=24'hFEDCBA -> fab_ack next cycle, owner=2, HEX0=0001000, HEX5=0001110 for 10 cycles, then owner=1 (hps_req=1) or 0.
REQ-029 key_n low with a 2-cycle bounce, then stable -> owner=3 only after 4 stable synchronized cycles; all HEX=0111111; release + 4 cycles -> prior owner restored.
REQ-030 fab_req at timer=3, new digits 24'h000001 -> timer back to 10, HEX0=1111001, second fab_ack.
REQ-031 fab_req in same cycle key_held rises, banner held 6 cycles -> owner=3, ack issued, then FAB for remaining 4 cycles.
REQ-032 reset_n pulsed low during FAB -> outputs 7'h7F and owner=0 asynchronously; no FAB after release without a new fab_req.
